// File: rtl/intpol2_d4_eval_seq.sv
// Sequencer/accumulator around a shared multiplier: evaluates y = p0 + p1*xi + p2*xi^2
// over n phases xi = n*h, building xi^2 by forward differences instead of a second multiplier.
module intpol2_d4_eval_seq #(
  parameter int DATAPATH_WIDTH = 32,
  parameter int N_bits         = 2,
  parameter int M_bits         = 31,
  parameter int NPTS_W         = 8,
  localparam int W             = DATAPATH_WIDTH + N_bits
) (
  input  logic              i_clk,
  input  logic              i_rstn,
  input  logic              i_coef_valid,
  output logic              o_coef_ready,
  input  logic [W-1:0]      i_p0,
  input  logic [W-1:0]      i_p1,
  input  logic [W-1:0]      i_p2,
  input  logic [W-1:0]      i_step,
  input  logic [W-1:0]      i_step_sq,
  input  logic [NPTS_W-1:0] i_n_points,
  output logic              o_sel_mult,
  output logic [W-1:0]      o_mp1,
  output logic [W-1:0]      o_mp2,
  output logic [W-1:0]      o_xi,
  output logic [W-1:0]      o_xi2,
  input  logic [W-1:0]      i_mult_out,
  output logic [W-1:0]      o_y,
  output logic              o_y_valid,
  input  logic              i_y_ready
);

  localparam int AW = W + 2;
  // h and h^2 lie in [0,1): only the fraction bits carry information
  localparam logic [W-1:0] FRAC_MASK = {{(W-M_bits){1'b0}}, {M_bits{1'b1}}};
  localparam logic [W-1:0] Y_MAX     = {1'b0, {(W-1){1'b1}}};
  localparam logic [W-1:0] Y_MIN     = {1'b1, {(W-1){1'b0}}};

  typedef enum logic [1:0] {IDLE, MUL1, MUL2, OUT} state_t;

  state_t r_state, w_next;

  logic [W-1:0]          r_p0, r_mp1, r_mp2, r_step, r_step_sq;
  logic [W-1:0]          r_xi, r_xi2, r_d, r_y;
  logic [NPTS_W-1:0]     r_npts, r_cnt;
  logic signed [AW-1:0]  r_acc;
  logic                  r_y_valid;

  logic signed [AW-1:0]  w_macc;
  logic [W-1:0]          w_ysat;
  logic [NPTS_W-1:0]     w_cnt_last;
  logic                  w_last;

  assign w_macc     = r_acc + AW'($signed(i_mult_out));
  assign w_cnt_last = (r_npts == '0) ? '0 : r_npts - NPTS_W'(1);
  assign w_last     = (r_cnt == w_cnt_last);

  // Bits above the W-bit result must all match its sign, else clamp
  always_comb begin
    w_ysat = w_macc[W-1:0];
    if (!(&w_macc[AW-1:W-1]) && (|w_macc[AW-1:W-1]))
      w_ysat = w_macc[AW-1] ? Y_MIN : Y_MAX;
  end

  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) r_state <= IDLE;
    else         r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:    if (i_coef_valid) w_next = MUL1;
      MUL1:    w_next = MUL2;
      MUL2:    w_next = OUT;
      OUT:     if (i_y_ready) w_next = w_last ? IDLE : MUL1;
      default: w_next = IDLE;
    endcase
  end

  always_comb begin
    o_coef_ready = (r_state == IDLE);
    o_sel_mult   = (r_state == MUL2);
  end

  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      r_p0      <= '0;
      r_mp1     <= '0;
      r_mp2     <= '0;
      r_step    <= '0;
      r_step_sq <= '0;
      r_npts    <= '0;
      r_xi      <= '0;
      r_xi2     <= '0;
      r_d       <= '0;
      r_cnt     <= '0;
      r_acc     <= '0;
      r_y       <= '0;
      r_y_valid <= 1'b0;
    end else begin
      case (r_state)
        IDLE: if (i_coef_valid) begin
          r_p0      <= i_p0;
          r_mp1     <= i_p1;
          r_mp2     <= i_p2;
          r_step    <= i_step & FRAC_MASK;
          r_step_sq <= i_step_sq & FRAC_MASK;
          r_npts    <= i_n_points;
          r_xi      <= '0;
          r_xi2     <= '0;
          r_d       <= i_step_sq & FRAC_MASK;
          r_cnt     <= '0;
          r_acc     <= AW'($signed(i_p0));
        end
        MUL1: r_acc <= w_macc;
        MUL2: begin
          r_acc     <= w_macc;
          r_y       <= w_ysat;
          r_y_valid <= 1'b1;
        end
        OUT: if (i_y_ready) begin
          // (n+1)^2 h^2 = n^2 h^2 + (2n+1) h^2; d holds the (2n+1) h^2 term
          r_y_valid <= 1'b0;
          r_xi      <= r_xi + r_step;
          r_xi2     <= r_xi2 + r_d;
          r_d       <= r_d + (r_step_sq << 1);
          r_cnt     <= r_cnt + NPTS_W'(1);
          r_acc     <= AW'($signed(r_p0));
        end
        default: ;
      endcase
    end
  end

  assign o_mp1     = r_mp1;
  assign o_mp2     = r_mp2;
  assign o_xi      = r_xi;
  assign o_xi2     = r_xi2;
  assign o_y       = r_y;
  assign o_y_valid = r_y_valid;

endmodule

// File: tb/tb_intpol2_d4_eval_seq.sv
// Directed bench for intpol2_d4_eval_seq with a behavioural model of the shared multiplier mux.
module tb_intpol2_d4_eval_seq;
  localparam int W = 34;

  logic i_clk = 1'b0;
  logic i_rstn, coef_valid, coef_ready, sel_mult, y_valid, y_ready;
  logic signed [W-1:0] p0, p1, p2, step, step_sq, mp1, mp2, xi, xi2, mult_out, y;
  logic [7:0] n_points;

  int n_checks = 0;
  int n_errors = 0;

  always #5 i_clk = ~i_clk;

  intpol2_d4_eval_seq dut (
    .i_clk(i_clk), .i_rstn(i_rstn), .i_coef_valid(coef_valid), .o_coef_ready(coef_ready),
    .i_p0(p0), .i_p1(p1), .i_p2(p2), .i_step(step), .i_step_sq(step_sq), .i_n_points(n_points),
    .o_sel_mult(sel_mult), .o_mp1(mp1), .o_mp2(mp2), .o_xi(xi), .o_xi2(xi2),
    .i_mult_out(mult_out), .o_y(y), .o_y_valid(y_valid), .i_y_ready(y_ready)
  );

  // Shared multiplier: Q31 product, arithmetic shift, truncated to W bits
  logic signed [67:0] m_a, m_b, m_prod;
  always_comb begin
    m_a      = sel_mult ? mp2 : mp1;
    m_b      = sel_mult ? xi2 : xi;
    m_prod   = m_a * m_b;
    mult_out = m_prod[64:31];
  end

  task automatic chk(input string tag, input logic signed [63:0] obs, input logic signed [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge i_clk);
    #1;
  endtask

  task automatic start_set(input logic signed [63:0] a0, a1, a2, h, hsq, input int n);
    p0 = a0[W-1:0]; p1 = a1[W-1:0]; p2 = a2[W-1:0];
    step = h[W-1:0]; step_sq = hsq[W-1:0]; n_points = n[7:0];
    coef_valid = 1'b1;
    chk("coef_ready_before_set", coef_ready, 1);
    tick();
    coef_valid = 1'b0;
    p0 = '1; p1 = '1; p2 = '1; step = '1; step_sq = '1; n_points = 8'd7;
  endtask

  // Wait (bounded) for y_valid, check y, then complete the handshake.
  task automatic expect_y(input string tag, input logic signed [63:0] exp, input int exp_wait);
    int waited = 0;
    y_ready = 1'b1;
    while (!y_valid && waited < 20) begin
      tick();
      waited++;
    end
    chk({tag, "_valid"}, y_valid, 1);
    chk(tag, y, exp);
    if (exp_wait >= 0) chk({tag, "_wait"}, waited, exp_wait);
    tick();
  endtask

  initial begin
    i_rstn = 1'b0; coef_valid = 1'b0; y_ready = 1'b0;
    p0 = '0; p1 = '0; p2 = '0; step = '0; step_sq = '0; n_points = '0;
    #12;
    chk("rst_coef_ready", coef_ready, 1);
    chk("rst_y_valid", y_valid, 0);
    chk("rst_sel_mult", sel_mult, 0);
    chk("rst_y", y, 0);
    chk("rst_xi", xi, 0);
    chk("rst_xi2", xi2, 0);
    chk("rst_mp2", mp2, 0);
    @(negedge i_clk);
    i_rstn = 1'b1;
    tick();

    // Pure quadratic: y tracks (n*0.25)^2
    start_set(0, 0, 64'sd2147483648, 64'sd536870912, 64'sd134217728, 4);
    chk("t1_coef_ready_busy", coef_ready, 0);
    expect_y("t1_y0", 0, 2);
    expect_y("t1_y1", 64'sd134217728, 2);
    expect_y("t1_y2", 64'sd536870912, 2);
    expect_y("t1_y3", 64'sd1207959552, 2);
    chk("t1_idle_after", coef_ready, 1);
    chk("t1_no_extra_y", y_valid, 0);

    // Linear ramp, continuous y_ready, also checks mux select pattern
    start_set(100, 64'sd2147483648, 0, 64'sd536870912, 64'sd134217728, 3);
    chk("t2_sel_mul1", sel_mult, 0);
    tick();
    chk("t2_sel_mul2", sel_mult, 1);
    tick();
    chk("t2_sel_out", sel_mult, 0);
    expect_y("t2_y0", 100, 0);
    expect_y("t2_y1", 64'sd536871012, 2);
    expect_y("t2_y2", 64'sd1073741924, 2);
    chk("t2_idle_after", coef_ready, 1);

    // Backpressure on second sample
    start_set(100, 64'sd2147483648, 0, 64'sd536870912, 64'sd134217728, 3);
    expect_y("t3_y0", 100, 2);
    y_ready = 1'b0;
    for (int i = 0; i < 8 && !y_valid; i++) tick();
    for (int i = 0; i < 5; i++) begin
      chk("t3_hold_valid", y_valid, 1);
      chk("t3_hold_y", y, 64'sd536871012);
      chk("t3_hold_xi", xi, 64'sd536870912);
      tick();
    end
    expect_y("t3_y1", 64'sd536871012, 0);
    expect_y("t3_y2", 64'sd1073741924, 2);
    chk("t3_idle_after", coef_ready, 1);

    // Saturation, positive and negative
    start_set(64'sd8589934591, 64'sd2147483648, 0, 64'sd1073741824, 0, 2);
    expect_y("t4_pos_y0", 64'sd8589934591, 2);
    expect_y("t4_pos_sat", 64'sd8589934591, 2);
    start_set(-64'sd8589934592, -64'sd2147483648, 0, 64'sd1073741824, 0, 2);
    expect_y("t4_neg_y0", -64'sd8589934592, 2);
    expect_y("t4_neg_sat", -64'sd8589934592, 2);

    // n_points=0 with coef_valid held high across the set
    p0 = -34'sd5; p1 = 34'sd123; p2 = 34'sd456; step = 34'sd536870912; step_sq = 34'sd134217728;
    n_points = 8'd0; coef_valid = 1'b1;
    tick();
    p0 = 34'sd777;
    chk("t5_busy_ignores_valid", coef_ready, 0);
    expect_y("t5_y_single", -5, 2);
    chk("t5_back_idle", coef_ready, 1);
    tick();
    coef_valid = 1'b0;
    chk("t5_second_accepted", coef_ready, 0);
    expect_y("t5_y_second", 777, 2);
    for (int i = 0; i < 4; i++) begin
      chk("t5_no_more_y", y_valid, 0);
      tick();
    end

    // Reset during MUL2 of second sample
    start_set(100, 64'sd2147483648, 0, 64'sd536870912, 64'sd134217728, 3);
    expect_y("t6_y0", 100, 2);
    tick();
    chk("t6_in_mul2", sel_mult, 1);
    #2 i_rstn = 1'b0;
    #1;
    chk("t6_rst_coef_ready", coef_ready, 1);
    chk("t6_rst_sel", sel_mult, 0);
    chk("t6_rst_y", y, 0);
    chk("t6_rst_xi", xi, 0);
    chk("t6_rst_mp1", mp1, 0);
    @(negedge i_clk);
    i_rstn = 1'b1;
    tick();
    chk("t6_no_y_after_rst", y_valid, 0);
    start_set(0, 0, 64'sd2147483648, 64'sd536870912, 64'sd134217728, 2);
    expect_y("t6_new_y0", 0, 2);
    expect_y("t6_new_y1", 64'sd134217728, 2);
    chk("t6_idle_after", coef_ready, 1);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end
endmodule
